// File: rtl/mem_loader_pkg.sv
// Shared definitions for the boot/program loader: FSM encoding and the
// default word/address widths used by the data memory blocks.
package mem_loader_pkg;

  localparam int DEF_WORD_LEN = 16;
  localparam int DEF_ADDR_LEN = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_loader_byte_packer.sv
// Packs an incoming byte stream MSB-first into a word; flags the byte that
// completes the word and presents the assembled word in that same cycle.
module byte_packer #(
  parameter int p_WORD_LEN = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_shift,
  input  logic [7:0]            i_byte,
  output logic [p_WORD_LEN-1:0] o_word,
  output logic                  o_word_complete
);

  localparam int p_BYTES_PER_WORD = p_WORD_LEN / 8;
  localparam int IDX_W = (p_BYTES_PER_WORD > 1) ? $clog2(p_BYTES_PER_WORD) : 1;

  logic [p_WORD_LEN-1:0] r_shift;
  logic [IDX_W-1:0]      r_idx;
  logic                  w_last;
  logic [p_WORD_LEN-1:0] w_next;

  assign w_last          = (r_idx == IDX_W'(p_BYTES_PER_WORD - 1));
  assign w_next          = (r_shift << 8) | p_WORD_LEN'(i_byte);
  // Word includes the byte being accepted so the caller can latch it directly.
  assign o_word          = w_next;
  assign o_word_complete = i_shift && w_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (i_shift) begin
      r_shift <= w_next;
      r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Sequential loader ahead of the data memory write port: streams bytes in,
// writes packed words to consecutive addresses, keeps a running checksum.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int p_WORD_LEN = DEF_WORD_LEN,
  parameter int p_ADDR_LEN = DEF_ADDR_LEN
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [p_ADDR_LEN-1:0] i_base_addr,
  input  logic [p_ADDR_LEN:0]   i_word_count,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte_data,
  output logic                  o_byte_ready,
  output logic                  o_mem_wr_en,
  output logic [p_ADDR_LEN-1:0] o_mem_addr,
  output logic [p_WORD_LEN-1:0] o_mem_wr_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [p_WORD_LEN-1:0] o_checksum
);

  state_t                r_state, w_next_state;
  logic [p_ADDR_LEN-1:0] r_addr;
  logic [p_ADDR_LEN:0]   r_remaining;
  logic [p_WORD_LEN-1:0] r_wr_data;
  logic [p_WORD_LEN-1:0] r_checksum;

  logic                  w_start;
  logic                  w_accept;
  logic                  w_word_complete;
  logic [p_WORD_LEN-1:0] w_word;

  assign w_start  = (r_state == ST_IDLE) && i_start;
  assign w_accept = (r_state == ST_RECV) && i_byte_valid;

  byte_packer #(.p_WORD_LEN(p_WORD_LEN)) u_packer (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_clear         (w_start),
    .i_shift         (w_accept),
    .i_byte          (i_byte_data),
    .o_word          (w_word),
    .o_word_complete (w_word_complete)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next_state = (i_word_count == '0) ? ST_DONE : ST_RECV;
      ST_RECV:  if (w_word_complete) w_next_state = ST_WRITE;
      ST_WRITE: w_next_state = (r_remaining == (p_ADDR_LEN+1)'(1)) ? ST_DONE : ST_RECV;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_wr_data   <= '0;
      r_checksum  <= '0;
    end else begin
      if (w_start) begin
        r_addr      <= i_base_addr;
        r_remaining <= i_word_count;
        r_checksum  <= '0;
      end
      if (w_word_complete) r_wr_data <= w_word;
      // Address wraps naturally at the register width, covering a full-memory load.
      if (r_state == ST_WRITE) begin
        r_checksum  <= r_checksum + r_wr_data;
        r_addr      <= r_addr + p_ADDR_LEN'(1);
        r_remaining <= r_remaining - (p_ADDR_LEN+1)'(1);
      end
    end
  end

  assign o_byte_ready  = (r_state == ST_RECV);
  assign o_mem_wr_en   = (r_state == ST_WRITE);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = (r_state == ST_DONE);
  assign o_mem_addr    = r_addr;
  assign o_mem_wr_data = r_wr_data;
  assign o_checksum    = r_checksum;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: table of two-word loads plus hand-written
// sequences for zero count and reset in the middle of a word.
module tb_mem_loader;

  localparam int WL = 16;
  localparam int AL = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [AL-1:0] i_base_addr;
  logic [AL:0]   i_word_count;
  logic          i_byte_valid;
  logic [7:0]    i_byte_data;
  logic          o_byte_ready, o_mem_wr_en, o_busy, o_done;
  logic [AL-1:0] o_mem_addr;
  logic [WL-1:0] o_mem_wr_data, o_checksum;

  mem_loader #(.p_WORD_LEN(WL), .p_ADDR_LEN(AL)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_word_count(i_word_count), .i_byte_valid(i_byte_valid), .i_byte_data(i_byte_data),
    .o_byte_ready(o_byte_ready), .o_mem_wr_en(o_mem_wr_en), .o_mem_addr(o_mem_addr),
    .o_mem_wr_data(o_mem_wr_data), .o_busy(o_busy), .o_done(o_done), .o_checksum(o_checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write/done monitor, sampled mid-cycle
  logic [AL-1:0] wa[$];
  logic [WL-1:0] wd[$];
  int            wc[$];
  int            dn = 0;
  always @(negedge clk) begin
    if (o_mem_wr_en) begin
      wa.push_back(o_mem_addr);
      wd.push_back(o_mem_wr_data);
      wc.push_back(cyc);
    end
    if (o_done) dn++;
  end

  int npass = 0, ntot = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [AL-1:0] base;
    logic [31:0]   stream;
    int            gap;
    bit            mid_start;
    logic [AL-1:0] a0, a1;
    logic [WL-1:0] d0, d1, sum;
  } vec_t;

  vec_t vecs[4];
  int   st_cyc, done_cyc;
  bit   found;

  task automatic clear_mon();
    wa.delete(); wd.delete(); wc.delete(); dn = 0;
  endtask

  task automatic start_load(input logic [AL-1:0] base, input logic [AL:0] cnt);
    i_base_addr = base; i_word_count = cnt; i_start = 1'b1;
    st_cyc = cyc;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input string name);
    bit ok = 0;
    i_byte_valid = 1'b1; i_byte_data = b;
    for (int i = 0; i < 20; i++) begin
      if (o_byte_ready) begin ok = 1; @(negedge clk); break; end
      @(negedge clk);
    end
    chk(name, ok, 1);
  endtask

  task automatic wait_done();
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (o_done) begin found = 1; done_cyc = cyc; break; end
      @(negedge clk);
    end
    #1;
    chk("done_seen", found, 1);
  endtask

  initial begin
    vecs[0] = '{base:10'h010, stream:32'h1234ABCD, gap:0, mid_start:0,
                a0:10'h010, a1:10'h011, d0:16'h1234, d1:16'hABCD, sum:16'hBE01};
    vecs[1] = '{base:10'h3FF, stream:32'h00010002, gap:0, mid_start:0,
                a0:10'h3FF, a1:10'h000, d0:16'h0001, d1:16'h0002, sum:16'h0003};
    vecs[2] = '{base:10'h010, stream:32'h1234ABCD, gap:2, mid_start:1,
                a0:10'h010, a1:10'h011, d0:16'h1234, d1:16'hABCD, sum:16'hBE01};
    vecs[3] = '{base:10'h200, stream:32'hFFFF0002, gap:0, mid_start:0,
                a0:10'h200, a1:10'h201, d0:16'hFFFF, d1:16'h0002, sum:16'h0001};

    rst = 1'b1; i_start = 0; i_base_addr = '0; i_word_count = '0;
    i_byte_valid = 0; i_byte_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_ready", o_byte_ready, 0);
    chk("rst_wr_en", o_mem_wr_en, 0);
    chk("rst_done", o_done, 0);
    chk("rst_checksum", o_checksum, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_wr_data", o_mem_wr_data, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", o_busy, 0);
    chk("idle_ready", o_byte_ready, 0);

    foreach (vecs[v]) begin
      clear_mon();
      start_load(vecs[v].base, 11'd2);
      chk("ready_after_start", o_byte_ready, 1);
      for (int j = 0; j < 4; j++) begin
        if (vecs[v].gap > 0) begin
          i_byte_valid = 1'b0;
          for (int g = 0; g < vecs[v].gap; g++) begin
            if (vecs[v].mid_start && j == 1 && g == 0) begin
              i_start = 1'b1; i_base_addr = 10'h300; i_word_count = 11'd5;
            end
            @(negedge clk);
            i_start = 1'b0;
          end
        end
        send_byte(vecs[v].stream[31-8*j -: 8], "byte_accept");
      end
      i_byte_valid = 1'b0;
      wait_done();
      chk("n_writes", wa.size(), 2);
      if (wa.size() == 2) begin
        chk("addr0", wa[0], vecs[v].a0);
        chk("data0", wd[0], vecs[v].d0);
        chk("addr1", wa[1], vecs[v].a1);
        chk("data1", wd[1], vecs[v].d1);
        chk("done_after_write", done_cyc - wc[1], 1);
        if (vecs[v].gap == 0) begin
          chk("first_write_lat", wc[0] - st_cyc, 3);
          chk("word_period", wc[1] - wc[0], 3);
        end
      end
      chk("checksum", o_checksum, vecs[v].sum);
      @(negedge clk);
      chk("done_pulse_1cyc", o_done, 0);
      chk("busy_after_done", o_busy, 0);
      repeat (3) @(negedge clk);
      chk("checksum_hold", o_checksum, vecs[v].sum);
      chk("done_count", dn, 1);
    end

    // Zero-length load
    clear_mon();
    start_load(10'h050, 11'd0);
    wait_done();
    chk("cnt0_done_lat", done_cyc - st_cyc, 1);
    chk("cnt0_checksum", o_checksum, 0);
    @(negedge clk);
    chk("cnt0_done_end", o_done, 0);
    chk("cnt0_n_writes", wa.size(), 0);

    // Reset after one byte of a word
    clear_mon();
    start_load(10'h100, 11'd1);
    send_byte(8'hAA, "byte_accept_rst");
    i_byte_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", o_busy, 0);
    chk("async_rst_ready", o_byte_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_write", wa.size(), 0);
    chk("rst_checksum_clr", o_checksum, 0);

    clear_mon();
    start_load(10'h020, 11'd1);
    send_byte(8'h55, "byte_accept_fresh");
    send_byte(8'h66, "byte_accept_fresh");
    i_byte_valid = 1'b0;
    wait_done();
    chk("fresh_n_writes", wa.size(), 1);
    if (wa.size() == 1) begin
      chk("fresh_addr", wa[0], 10'h020);
      chk("fresh_data", wd[0], 16'h5566);
    end
    chk("fresh_checksum", o_checksum, 16'h5566);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
